// File: rtl/game_status.sv
// rtl/game_status.sv - round FSM, pellet grid, score and pellet colour layer for a pacman-style game.
// Define GHOST_COLLISION_EN to make a pacman/ghost overlap end the round as a loss.
module game_status #(
  parameter int WIN_SCORE    = 30,
  parameter int PELLET_X0    = 40,
  parameter int PELLET_Y0    = 40,
  parameter int PELLET_PITCH = 80,
  parameter int PELLET_COLS  = 8,
  parameter int PELLET_ROWS  = 6,
  parameter int COLLIDE_DIST = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        ack,
  input  logic [9:0]  pacX,
  input  logic [9:0]  pacY,
  input  logic [9:0]  ghostX,
  input  logic [9:0]  ghostY,
  input  logic        bright,
  input  logic [9:0]  hCount,
  input  logic [9:0]  vCount,
  output logic [15:0] score,
  output logic        win,
  output logic        lose,
  output logic        pelletFill,
  output logic [11:0] rgb
);

  localparam int NPEL = PELLET_COLS * PELLET_ROWS;

  typedef enum logic [1:0] {IDLE, PLAY, WIN, LOSE} state_t;

  state_t          state_q, state_d;
  logic [15:0]     score_q, score_d;
  logic [NPEL-1:0] pellets_q, pellets_d;
  logic [NPEL-1:0] eat_mask;
  logic            eat_hit;
  logic            ghost_hit;

  // Integer arithmetic so a pixel left of / above a centre never wraps.
  function automatic logic near(input logic [9:0] a, input int centre, input int lim);
    int d;
    d = int'(a) - centre;
    if (d < 0) d = -d;
    return (d <= lim);
  endfunction

  function automatic int pel_x(input int i);
    return PELLET_X0 + (i % PELLET_COLS) * PELLET_PITCH;
  endfunction

  function automatic int pel_y(input int i);
    return PELLET_Y0 + (i / PELLET_COLS) * PELLET_PITCH;
  endfunction

  // Lowest-index uneaten pellet under pacman wins when several qualify.
  always_comb begin
    eat_hit  = 1'b0;
    eat_mask = '0;
    for (int i = 0; i < NPEL; i++) begin
      if (!eat_hit && pellets_q[i] && near(pacX, pel_x(i), 2) && near(pacY, pel_y(i), 2)) begin
        eat_hit     = 1'b1;
        eat_mask[i] = 1'b1;
      end
    end
  end

`ifdef GHOST_COLLISION_EN
  assign ghost_hit = near(pacX, int'(ghostX), COLLIDE_DIST) &&
                     near(pacY, int'(ghostY), COLLIDE_DIST);
`else
  logic unused_ghost;
  assign unused_ghost = ^{ghostX, ghostY};
  assign ghost_hit    = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    score_d   = score_q;
    pellets_d = pellets_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = PLAY;
          score_d   = '0;
          pellets_d = '1;
        end
      end
      PLAY: begin
        if (eat_hit) begin
          pellets_d = pellets_q & ~eat_mask;
          if (score_q != 16'hFFFF) score_d = score_q + 16'd1;
        end
        if (eat_hit && score_d == 16'(WIN_SCORE)) state_d = WIN;
        else if (ghost_hit)                       state_d = LOSE;
      end
      WIN, LOSE: begin
        if (ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      score_q   <= '0;
      pellets_q <= '1;
    end else begin
      state_q   <= state_d;
      score_q   <= score_d;
      pellets_q <= pellets_d;
    end
  end

  always_comb begin
    pelletFill = 1'b0;
    for (int i = 0; i < NPEL; i++) begin
      if (pellets_q[i] && near(hCount, pel_x(i), 1) && near(vCount, pel_y(i), 1))
        pelletFill = bright;
    end
  end

  assign rgb   = pelletFill ? 12'hFFF : 12'h000;
  assign score = score_q;
  assign win   = (state_q == WIN);
`ifdef GHOST_COLLISION_EN
  assign lose  = (state_q == LOSE);
`else
  assign lose  = 1'b0;
`endif

endmodule
